cpu_mem_sequencer: RTL

Run controller and RAM-port arbiter for the VerySimpleCPU subsystem. It sits between the single-port program/data RAM, the CPU core and a host port. The host streams a program into RAM and starts execution. The block holds the CPU in reset except during a run, detects the halt write, and optionally enforces a cycle limit. Between runs, the host reads RAM back through the same port.

---
 rtl/vscpu_pkg.sv | 38 +++
 rtl/vscpu_port_mux.sv | 40 ++++
 rtl/cpu_mem_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/vscpu_pkg.sv
// Shared types and constants for the VerySimpleCPU subsystem: run states, RAM-port
// selects, default widths/halt address, and opcode constants for assembling programs.
package vscpu_pkg;

    localparam int unsigned     DefAddrW    = 14;
    localparam int unsigned     DefDataW    = 32;
    localparam logic [13:0]     DefHaltAddr = 14'h3FFF;

    typedef enum logic {
        StIdle,
        StRun
    } seq_state_e;

    typedef enum logic [1:0] {
        SelNone,
        SelLoad,
        SelRead,
        SelCpu
    } port_sel_e;

    typedef enum logic [2:0] {
        OpAdd  = 3'd0,
        OpNand = 3'd1,
        OpSrl  = 3'd2,
        OpLt   = 3'd3,
        OpCp   = 3'd4,
        OpCpi  = 3'd5,
        OpBzj  = 3'd6,
        OpMul  = 3'd7
    } opcode_e;

    // Instruction word layout: {opcode, immediate flag, A operand, B operand}.
    function automatic logic [31:0] vscpu_insn(input opcode_e op, input logic imm,
                                               input logic [13:0] a, input logic [13:0] b);
        return {op, imm, a, b};
    endfunction

endpackage

// File: rtl/vscpu_port_mux.sv
// Combinational RAM-port mux: steers the single RAM port to a host load beat,
// a host readback, or the CPU according to the select computed by the sequencer.
module vscpu_port_mux
    import vscpu_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
) (
    input  port_sel_e           sel,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [DATA_W-1:0]   load_data,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic                cpu_wrEn,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_data_out,
    output logic                ram_wrEn,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_data_wr
);

    always_comb begin
        ram_wrEn    = 1'b0;
        ram_addr    = '0;
        ram_data_wr = load_data;
        unique case (sel)
            SelLoad: begin
                ram_wrEn = 1'b1;
                ram_addr = load_addr;
            end
            SelRead: ram_addr = rd_addr;
            SelCpu: begin
                ram_wrEn    = cpu_wrEn;
                ram_addr    = cpu_addr;
                ram_data_wr = cpu_data_out;
            end
            SelNone: ;
        endcase
    end

endmodule

// File: rtl/cpu_mem_sequencer.sv
// Run controller and RAM-port arbiter for VerySimpleCPU. Define RUN_CYCLE_LIMIT_EN to end
// runs that reach MAX_CYCLES with timeout=1; otherwise runs are unbounded and timeout is 0.
module cpu_mem_sequencer
    import vscpu_pkg::*;
#(
    parameter int unsigned          ADDR_W     = DefAddrW,
    parameter int unsigned          DATA_W     = DefDataW,
    parameter logic [ADDR_W-1:0]    HALT_ADDR  = ADDR_W'(DefHaltAddr),
    parameter logic [31:0]          MAX_CYCLES = 32'd1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [DATA_W-1:0]   load_data,
    input  logic                load_last,
    input  logic                start,
    input  logic                abort,
    input  logic                rd_req,
    output logic                rd_ready,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [31:0]         cycles,
    output logic                cpu_rst,
    input  logic                cpu_wrEn,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_data_out,
    output logic [DATA_W-1:0]   cpu_data_in,
    output logic                ram_wrEn,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_data_wr,
    input  logic [DATA_W-1:0]   ram_data_rd
);

`ifdef RUN_CYCLE_LIMIT_EN
    localparam bit LimitEn = 1'b1;
`else
    localparam bit LimitEn = 1'b0;
`endif

    seq_state_e         state_q;
    logic [ADDR_W-1:0]  ptr_q;
    logic               done_q, timeout_q, rd_valid_q;
    logic [31:0]        cycles_q, cycles_inc;
    logic               is_idle, is_run, load_fire, rd_fire, halt, limit_hit;
    port_sel_e          sel;

    // Outputs are qualified with rst so they hold their reset values during the whole
    // reset window, not only after the first sampled edge.
    assign is_idle    = rst && (state_q == StIdle);
    assign is_run     = rst && (state_q == StRun);
    assign load_fire  = is_idle && !start && load_valid;
    assign rd_fire    = is_idle && !start && !load_valid && rd_req;
    assign halt       = cpu_wrEn && (cpu_addr == HALT_ADDR);
    assign cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + 32'd1;
    assign limit_hit  = LimitEn && (cycles_inc == MAX_CYCLES);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cycles_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StRun;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        cycles_q  <= '0;
                        ptr_q     <= '0;
                    end else if (load_valid) begin
                        ptr_q     <= load_last ? '0 : ptr_q + ADDR_W'(1);
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                StRun: begin
                    cycles_q <= cycles_inc;
                    // Halt beats abort and the cycle limit when they coincide.
                    if (halt) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end else if (abort) begin
                        state_q   <= StIdle;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                    end else if (limit_hit) begin
                        state_q   <= StIdle;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        sel = SelNone;
        if (is_run) begin
            sel = SelCpu;
        end else if (load_fire) begin
            sel = SelLoad;
        end else if (rd_fire) begin
            sel = SelRead;
        end
    end

    vscpu_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port_mux (
        .sel          (sel),
        .load_addr    (ptr_q),
        .load_data    (load_data),
        .rd_addr      (rd_addr),
        .cpu_wrEn     (cpu_wrEn),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .ram_wrEn     (ram_wrEn),
        .ram_addr     (ram_addr),
        .ram_data_wr  (ram_data_wr)
    );

    assign busy        = is_run;
    assign cpu_rst     = !is_run;
    assign load_ready  = is_idle && !start;
    assign rd_ready    = is_idle && !start && !load_valid;
    assign rd_valid    = rst && rd_valid_q;
    assign rd_data     = ram_data_rd;
    assign cpu_data_in = ram_data_rd;
    assign done        = rst && done_q;
    assign timeout     = rst && LimitEn && timeout_q;
    assign cycles      = rst ? cycles_q : '0;

endmodule
